// File: rtl/fix_pkg.sv
// Shared FIX framing constants, FSM state types and the checksum-trailer
// step function used by the session arbiter and the parser.
package fix_pkg;

  localparam logic [7:0] SOH_C = 8'h01;
  localparam logic [7:0] SEP_C = 8'h3d;
  localparam logic [7:0] ASC_1 = 8'h31;
  localparam logic [7:0] ASC_0 = 8'h30;

  typedef enum logic {
    ARB,
    XFER
  } arb_state_t;

  typedef enum logic [2:0] {
    T_SOH,
    T_BODY,
    T_1,
    T_10,
    T_CK
  } trl_state_t;

  // True when byte b, seen in detector state cur, is the trailer's closing SOH.
  function automatic logic trl_is_end(input trl_state_t cur, input logic [7:0] b);
    return (cur == T_CK) && (b == SOH_C);
  endfunction

  // Advance the "SOH 1 0 =" tag matcher by one byte. Once the checksum tag
  // has been seen the detector stays in T_CK until its closing SOH.
  function automatic trl_state_t trl_step(input trl_state_t cur, input logic [7:0] b);
    trl_state_t nxt;
    nxt = T_BODY;
    if (cur == T_CK) begin
      nxt = T_CK;
    end else if (b == SOH_C) begin
      nxt = T_SOH;
    end else begin
      case (cur)
        T_SOH:   nxt = (b == ASC_1) ? T_1  : T_BODY;
        T_1:     nxt = (b == ASC_0) ? T_10 : T_BODY;
        T_10:    nxt = (b == SEP_C) ? T_CK : T_BODY;
        default: nxt = T_BODY;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fix_rr_arb.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr, wrapping modulo N. Purely combinational so schedulers can register
// the result however they like.
module fix_rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [N-1:0] hit;

  // Requests rotated so that hit[0] corresponds to the session at ptr.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign hit[gi] = req[(int'(ptr) + gi) % N];
  end

  // Scan offsets from the far end down so the smallest offset wins.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        gnt_idx = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fix_session_arb.sv
// Multiplexes several FIX session byte streams onto one parser stream.
// A session keeps the grant for one whole message; the end of a message is
// found by watching for the checksum trailer, with a forced cut after
// MAX_MSG_LEN bytes so a runaway session cannot starve the others.
module fix_session_arb
  import fix_pkg::*;
#(
  parameter int NUM_SESS    = 4,
  parameter int MAX_MSG_LEN = 1024,
  parameter int SESS_W      = $clog2(NUM_SESS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SESS-1:0]      req_valid_i,
  input  logic [NUM_SESS-1:0][7:0] req_data_i,
  output logic [NUM_SESS-1:0]      req_ready_o,
  input  logic                     par_ready_i,
  output logic                     valid_o,
  output logic [7:0]               data_o,
  output logic [SESS_W-1:0]        sess_o,
  output logic                     msg_start_o,
  output logic                     msg_end_o,
  output logic                     err_len_o
);

  localparam int                LEN_W    = $clog2(MAX_MSG_LEN + 1);
  localparam logic [LEN_W-1:0]  LAST_LEN = LEN_W'(MAX_MSG_LEN - 1);
  localparam logic [SESS_W-1:0] LAST_SES = SESS_W'(NUM_SESS - 1);

  arb_state_t        state_reg, state_next;
  logic [SESS_W-1:0] grant_reg, grant_next;
  logic [SESS_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  trl_state_t        trl_reg, trl_next;

  logic [SESS_W-1:0] pick_idx;
  logic              pick_any;
  logic              in_xfer;
  logic              cur_valid;
  logic [7:0]        cur_data;
  logic              trl_end;
  logic              len_cut;
  logic              end_byte;
  logic              xfer;

  fix_rr_arb #(
    .N (NUM_SESS),
    .W (SESS_W)
  ) u_rr_arb (
    .req     (req_valid_i),
    .ptr     (rr_ptr_reg),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign in_xfer   = (state_reg == XFER);
  assign cur_valid = req_valid_i[grant_reg];
  assign cur_data  = req_data_i[grant_reg];

  // The trailer wins over the length cut when both land on the same byte.
  assign trl_end  = trl_is_end(trl_reg, cur_data);
  assign len_cut  = (len_reg == LAST_LEN) && !trl_end;
  assign end_byte = trl_end || len_cut;

  // valid_o depends only on state and the granted request, never on par_ready_i.
  assign valid_o     = in_xfer && cur_valid;
  assign data_o      = in_xfer ? cur_data : 8'h00;
  assign sess_o      = in_xfer ? grant_reg : '0;
  assign msg_start_o = valid_o && (len_reg == '0);
  assign msg_end_o   = valid_o && end_byte;
  assign err_len_o   = valid_o && len_cut;
  assign xfer        = valid_o && par_ready_i;

  // Back-pressure only the granted session; everyone else waits.
  for (genvar gi = 0; gi < NUM_SESS; gi++) begin : g_ready
    assign req_ready_o[gi] = in_xfer && (grant_reg == SESS_W'(gi)) && par_ready_i;
  end

  // Next-state logic: arbitrate in ARB, track trailer and length per transfer in XFER.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    len_next    = len_reg;
    trl_next    = trl_reg;
    case (state_reg)
      ARB: begin
        if (pick_any) begin
          grant_next = pick_idx;
          state_next = XFER;
          len_next   = '0;
          trl_next   = T_SOH;
        end
      end
      XFER: begin
        if (xfer) begin
          if (end_byte) begin
            state_next  = ARB;
            rr_ptr_next = (grant_reg == LAST_SES) ? '0 : grant_reg + 1'b1;
            len_next    = '0;
            trl_next    = T_SOH;
          end else begin
            len_next = len_reg + 1'b1;
            trl_next = trl_step(trl_reg, cur_data);
          end
        end
      end
      default: begin
        state_next = ARB;
      end
    endcase
  end

  // State registers; reset drops any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      len_reg    <= '0;
      trl_reg    <= T_SOH;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      len_reg    <= len_next;
      trl_reg    <= trl_next;
    end
  end

endmodule

// File: tb/tb_fix_session_arb.sv
// Directed bench for fix_session_arb: two instances (default length limit
// and a 16-byte limit) fed from per-session byte sources; every forwarded
// byte is logged and compared against hand-written messages.
`timescale 1ns/1ps
module tb_fix_session_arb;

  localparam int NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                par_ready;
  logic [NS-1:0]       req_valid [2];
  logic [NS-1:0][7:0]  req_data  [2];
  logic [NS-1:0]       req_ready [2];
  logic                valid     [2];
  logic [7:0]          data      [2];
  logic [1:0]          sess      [2];
  logic                mstart    [2];
  logic                mend      [2];
  logic                merr      [2];

  fix_session_arb #(.NUM_SESS(NS), .MAX_MSG_LEN(1024)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[0]), .req_data_i(req_data[0]), .req_ready_o(req_ready[0]),
    .par_ready_i(par_ready),
    .valid_o(valid[0]), .data_o(data[0]), .sess_o(sess[0]),
    .msg_start_o(mstart[0]), .msg_end_o(mend[0]), .err_len_o(merr[0])
  );

  fix_session_arb #(.NUM_SESS(NS), .MAX_MSG_LEN(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[1]), .req_data_i(req_data[1]), .req_ready_o(req_ready[1]),
    .par_ready_i(par_ready),
    .valid_o(valid[1]), .data_o(data[1]), .sess_o(sess[1]),
    .msg_start_o(mstart[1]), .msg_end_o(mend[1]), .err_len_o(merr[1])
  );

  // Per-session byte sources and per-instance transfer logs.
  logic [7:0] src_mem [2][NS][64];
  int         src_wr  [2][NS];
  int         src_rd  [2][NS];
  logic [7:0] lg_data  [2][256];
  logic [1:0] lg_sess  [2][256];
  logic [2:0] lg_flags [2][256];
  int         lg_cyc   [2][256];
  int         lg_cnt   [2];
  int         cyc;
  bit         gap_en;
  int         n_checks;
  int         n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] chr(input string m, input int i);
    logic [7:0] b;
    b = m[i];
    return (b == 8'h5e) ? 8'h01 : b;
  endfunction

  task automatic load(input int d, input int s, input string m);
    for (int i = 0; i < m.len(); i++) begin
      src_mem[d][s][src_wr[d][s]] = chr(m, i);
      src_wr[d][s]++;
    end
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      lg_cnt[d] = 0;
      for (int s = 0; s < NS; s++) begin
        src_wr[d][s] = 0;
        src_rd[d][s] = 0;
      end
    end
  endtask

  // One clock: drive at the falling edge, observe 2 ns later, then move on.
  task automatic cycle();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < NS; s++) begin
        req_valid[d][s] = (src_rd[d][s] != src_wr[d][s]) && (!gap_en || $urandom_range(3) != 0);
        req_data[d][s]  = (src_rd[d][s] != src_wr[d][s]) ? src_mem[d][s][src_rd[d][s]] : 8'h00;
      end
    end
    par_ready = !gap_en || ($urandom_range(3) != 0);
    #2;
    for (int d = 0; d < 2; d++) begin
      if (!rst && valid[d] && par_ready && lg_cnt[d] < 256) begin
        lg_data[d][lg_cnt[d]]  = data[d];
        lg_sess[d][lg_cnt[d]]  = sess[d];
        lg_flags[d][lg_cnt[d]] = {mstart[d], mend[d], merr[d]};
        lg_cyc[d][lg_cnt[d]]   = cyc;
        $display("xfer dut%0d cyc=%0d sess=%0d data=%02h start=%0b end=%0b err=%0b",
                 d, cyc, sess[d], data[d], mstart[d], mend[d], merr[d]);
        lg_cnt[d]++;
      end
      for (int s = 0; s < NS; s++) begin
        if (req_valid[d][s] && req_ready[d][s]) src_rd[d][s]++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run(input int d, input int n, input int budget);
    int k;
    k = 0;
    while (lg_cnt[d] < n && k < budget) begin
      cycle();
      k++;
    end
    check($sformatf("dut%0d_xfer_count", d), lg_cnt[d], n);
  endtask

  task automatic expect_msg(input int d, input int base, input int s, input string m,
                            input bit end_last, input bit err_last);
    int n;
    n = m.len();
    for (int i = 0; i < n; i++) begin
      check($sformatf("dut%0d_data[%0d]", d, base + i), lg_data[d][base + i], chr(m, i));
      check($sformatf("dut%0d_sess[%0d]", d, base + i), lg_sess[d][base + i], s);
      check($sformatf("dut%0d_flags[%0d]", d, base + i), lg_flags[d][base + i],
            {i == 0, (i == n - 1) && end_last, (i == n - 1) && err_last});
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_dut%0d", tag, d),
            {req_ready[d], valid[d], data[d], sess[d], mstart[d], mend[d], merr[d]}, 0);
    end
  endtask

  string m1, m3, m6, ms;
  int    total;
  int    chk_ptr [NS];
  int    n_end   [NS];
  int    interleave;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    gap_en   = 1'b0;
    rst      = 1'b1;
    par_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_data[d]  = '0;
    end
    clear_all();
    @(negedge clk);
    cycle();
    cycle();
    check_idle("reset_outputs");
    rst = 1'b0;

    // Single session, back-to-back copies: passthrough, flags, one bubble.
    do_reset();
    m1 = "8=FIX.4.2^9=5^35=0^10=123^";
    load(0, 0, m1);
    load(0, 0, m1);
    total = cyc;
    run(0, 52, 200);
    expect_msg(0, 0, 0, m1, 1'b1, 1'b0);
    expect_msg(0, 26, 0, m1, 1'b1, 1'b0);
    check("first_byte_latency", lg_cyc[0][0] - total, 1);
    check("msg_throughput", lg_cyc[0][25] - lg_cyc[0][0], 25);
    check("arb_bubble", lg_cyc[0][26] - lg_cyc[0][25], 2);

    // Four sessions, three messages each: round-robin order from session 0.
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < NS; s++)
        load(0, s, $sformatf("%c^10=%0d^", 8'h41 + s, k));
    run(0, 84, 400);
    for (int m = 0; m < 12; m++) begin
      expect_msg(0, m * 7, m % 4, $sformatf("%c^10=%0d^", 8'h41 + (m % 4), m / 4), 1'b1, 1'b0);
      if (m > 0) check($sformatf("rr_bubble[%0d]", m), lg_cyc[0][m * 7] - lg_cyc[0][m * 7 - 1], 2);
    end

    // Look-alike tags inside the body must not end the message.
    do_reset();
    m3 = "35=D^100=7^x10=9^10=045^";
    load(0, 1, m3);
    load(0, 1, "Z^10=1^");
    run(0, 31, 200);
    expect_msg(0, 0, 1, m3, 1'b1, 1'b0);
    expect_msg(0, 24, 1, "Z^10=1^", 1'b1, 1'b0);

    // 16-byte limit: forced cut, pending session served, remainder regranted.
    do_reset();
    load(1, 2, "ABCDEFGHIJKLMNOPQRST");
    load(1, 3, "Z^10=5^");
    run(1, 27, 200);
    expect_msg(1, 0, 2, "ABCDEFGHIJKLMNOP", 1'b1, 1'b1);
    expect_msg(1, 16, 3, "Z^10=5^", 1'b1, 1'b0);
    expect_msg(1, 23, 2, "QRST", 1'b0, 1'b0);

    // Trailer end landing exactly on the length limit is not an error.
    do_reset();
    load(1, 0, "ABCDEFGHI^10=12^");
    load(1, 0, "Y^10=3^");
    run(1, 23, 200);
    expect_msg(1, 0, 0, "ABCDEFGHI^10=12^", 1'b1, 1'b0);
    expect_msg(1, 16, 0, "Y^10=3^", 1'b1, 1'b0);

    // Random back-pressure and valid gaps: per-session streams intact.
    do_reset();
    total = 0;
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < 2; k++) begin
        ms = $sformatf("%0d=s%0d^10=%0d^", 40 + s, k, s + k);
        load(0, s, ms);
        total += ms.len();
      end
      chk_ptr[s] = 0;
      n_end[s]   = 0;
    end
    gap_en = 1'b1;
    run(0, total, 3000);
    gap_en = 1'b0;
    interleave = 0;
    for (int i = 0; i < lg_cnt[0]; i++) begin
      check($sformatf("rand_data[%0d]", i), lg_data[0][i],
            src_mem[0][lg_sess[0][i]][chk_ptr[lg_sess[0][i]]]);
      chk_ptr[lg_sess[0][i]]++;
      if (lg_flags[0][i][1]) n_end[lg_sess[0][i]]++;
      if (i > 0 && lg_sess[0][i] != lg_sess[0][i - 1] && !lg_flags[0][i - 1][1]) interleave++;
    end
    check("rand_interleave", interleave, 0);
    for (int s = 0; s < NS; s++) begin
      check($sformatf("rand_len_s%0d", s), chk_ptr[s], src_wr[0][s]);
      check($sformatf("rand_ends_s%0d", s), n_end[s], 2);
    end

    // Reset mid-message on session 1, then resend alongside session 3.
    do_reset();
    m6 = "35=A^58=hello^10=77^";
    load(0, 1, m6);
    run(0, 5, 50);
    check("pre_reset_data4", lg_data[0][4], chr(m6, 4));
    rst = 1'b1;
    cycle();
    cycle();
    check_idle("mid_reset_outputs");
    clear_all();
    load(0, 3, "W^10=2^");
    load(0, 1, m6);
    rst = 1'b0;
    run(0, m6.len() + 7, 300);
    expect_msg(0, 0, 1, m6, 1'b1, 1'b0);
    expect_msg(0, m6.len(), 3, "W^10=2^", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
